// File: rtl/sha256d_job_ctrl_if.sv
// sha256d_job_ctrl_if: host config/status and SHA-256d core word bus of the job controller
interface sha256d_job_ctrl_if #(
    parameter int HCNT_W = 32
);
    logic              cfg_we;
    logic [4:0]        cfg_addr;
    logic [31:0]       cfg_wdata;
    logic              go;
    logic              abort;
    logic              busy;
    logic              found;
    logic              exhausted;
    logic [31:0]       found_nonce;
    logic [255:0]      found_hash;
    logic [HCNT_W-1:0] hash_count;
    logic              sha_start;
    logic              sha_rq;
    logic [4:0]        sha_addr;
    logic [31:0]       sha_data;
    logic              sha_rdy;
    logic [255:0]      sha_hash;
    logic              sha_done;

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, go, abort, sha_rq, sha_addr, sha_hash, sha_done,
        output busy, found, exhausted, found_nonce, found_hash, hash_count, sha_start, sha_data, sha_rdy
    );

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, go, abort, sha_rq, sha_addr, sha_hash, sha_done,
        input  busy, found, exhausted, found_nonce, found_hash, hash_count, sha_start, sha_data, sha_rdy
    );
endinterface

// File: rtl/sha256d_job_ctrl.sv
// sha256d_job_ctrl: sequences a SHA-256d core across a nonce range and reports the first winner
module sha256d_job_ctrl #(
    parameter int HCNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    sha256d_job_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, WAIT, CHECK, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       hdr_q [19];
    logic [255:0]      target_q, hash_q, found_hash_q, value;
    logic [31:0]       nonce_start_q, nonce_end_q, nonce_q, found_nonce_q, word;
    logic [HCNT_W-1:0] hash_count_q;
    logic              found_q, exhausted_q, abort_q, done_q;
    logic              done_edge, serve, hit, last, stop;
    logic [2:0]        tidx;

    // Core may hold done high for several cycles; only the rising edge ends a run
    assign done_edge = bus.sha_done & ~done_q;
    assign serve     = (state_q == START) || (state_q == WAIT) || (state_q == DRAIN);
    assign hit       = value <= target_q;
    assign last      = nonce_q == nonce_end_q;
    // An abort seen together with the final done stops the job after its check
    assign stop      = abort_q | bus.abort;
    // Target word 20 is the most significant, so word 27 lands in bits 31:0
    assign tidx      = 3'(5'd27 - bus.cfg_addr);

    // Byte-reversed digest is the little-endian integer compared against the target
    for (genvar i = 0; i < 32; i++) begin : g_rev
        assign value[8*i +: 8] = hash_q[255-8*i -: 8];
    end

    // Header words straight through, nonce byte-swapped into the header's little-endian slot
    assign word = (bus.sha_addr < 5'd19) ? hdr_q[bus.sha_addr] :
                  (bus.sha_addr == 5'd19) ? {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]} :
                  32'd0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.go) state_d = START;
            START:   state_d = bus.abort ? DRAIN : WAIT;
            WAIT:    if (done_edge) state_d = CHECK;
                     else if (bus.abort) state_d = DRAIN;
            CHECK:   state_d = (hit || last || stop) ? IDLE : START;
            DRAIN:   if (done_edge) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state; the word bus answers with zero wait states
    always_comb begin
        bus.busy      = state_q != IDLE;
        bus.sha_start = state_q == START;
        bus.sha_rdy   = serve & bus.sha_rq;
        bus.sha_data  = serve ? word : 32'd0;
    end

    assign bus.found       = found_q;
    assign bus.exhausted   = exhausted_q;
    assign bus.found_nonce = found_nonce_q;
    assign bus.found_hash  = found_hash_q;
    assign bus.hash_count  = hash_count_q;

    // Config storage, per-job nonce walk, digest capture and result reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 19; k++) hdr_q[k] <= '0;
            target_q      <= '0;
            nonce_start_q <= '0;
            nonce_end_q   <= '0;
            nonce_q       <= '0;
            hash_q        <= '0;
            found_hash_q  <= '0;
            found_nonce_q <= '0;
            hash_count_q  <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            abort_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= bus.sha_done;
            if (bus.cfg_we && state_q == IDLE) begin
                if (bus.cfg_addr < 5'd19) hdr_q[bus.cfg_addr] <= bus.cfg_wdata;
                else if (bus.cfg_addr == 5'd19) nonce_start_q <= bus.cfg_wdata;
                else if (bus.cfg_addr <= 5'd27) target_q[{tidx, 5'd0} +: 32] <= bus.cfg_wdata;
                else if (bus.cfg_addr == 5'd28) nonce_end_q <= bus.cfg_wdata;
            end
            if (state_q == IDLE && bus.go) begin
                nonce_q      <= nonce_start_q;
                found_q      <= 1'b0;
                exhausted_q  <= 1'b0;
                hash_count_q <= '0;
                abort_q      <= 1'b0;
            end
            if (state_q == WAIT && done_edge) begin
                hash_q  <= bus.sha_hash;
                abort_q <= bus.abort;
                if (~&hash_count_q) hash_count_q <= hash_count_q + HCNT_W'(1);
            end
            if (state_q == CHECK) begin
                if (hit) begin
                    found_q       <= 1'b1;
                    found_nonce_q <= nonce_q;
                    found_hash_q  <= hash_q;
                end else if (last) begin
                    exhausted_q <= 1'b1;
                end else if (!stop) begin
                    nonce_q <= nonce_q + 32'd1;
                end
            end
        end
    end
endmodule
